// File: rtl/index_to_mask.sv
// Collects a stream of spin indices into a NUM_SPINS-wide mask plus its distinct-ones count.
// The mask is presented once the list ends and is held until the consumer accepts it.
//
// state  | meaning
// ACCUM  | accepting index beats, mask/count/flags being built
// OUTPUT | finished mask presented, waiting for out_ready
module index_to_mask #(
  parameter int NUM_SPINS = 256,
  parameter int IDX_W     = $clog2(NUM_SPINS),
  parameter int CNT_W     = $clog2(NUM_SPINS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IDX_W-1:0]     in_index,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_SPINS-1:0] out_mask,
  output logic [CNT_W-1:0]     out_count,
  output logic                 out_dup_err,
  output logic                 out_range_err
);

  typedef enum logic {
    ACCUM  = 1'b0,
    OUTPUT = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_SPINS-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   dup_q, dup_d;
  logic                   range_q, range_d;
  logic                   range_bad;

  // Out-of-range indices only exist when the index width over-covers the spin count.
  generate
    if (NUM_SPINS == (1 << IDX_W)) begin : g_pow2
      assign range_bad = 1'b0;
    end else begin : g_npow2
      assign range_bad = (int'(in_index) >= NUM_SPINS);
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    count_d = count_q;
    dup_d   = dup_q;
    range_d = range_q;
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          if (range_bad) begin
            range_d = 1'b1;
          end else if (mask_q[in_index]) begin
            dup_d = 1'b1;
          end else begin
            mask_d[in_index] = 1'b1;
            count_d          = count_q + CNT_W'(1);
          end
          if (in_last) begin
            state_d = OUTPUT;
          end
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          state_d = ACCUM;
          mask_d  = '0;
          count_d = '0;
          dup_d   = 1'b0;
          range_d = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ACCUM;
      mask_q  <= '0;
      count_q <= '0;
      dup_q   <= 1'b0;
      range_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      count_q <= count_d;
      dup_q   <= dup_d;
      range_q <= range_d;
    end
  end

  assign in_ready      = (state_q == ACCUM);
  assign out_valid     = (state_q == OUTPUT);
  assign out_mask      = mask_q;
  assign out_count     = count_q;
  assign out_dup_err   = dup_q;
  assign out_range_err = range_q;

  a_count_is_popcount: assert property (@(posedge clk) disable iff (reset)
    int'(count_q) == $countones(mask_q));

endmodule

// File: tb/tb_index_to_mask.sv
// Directed bench for index_to_mask: a 256-spin instance and a 10-spin instance for range errors.
module tb_index_to_mask;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid, in_last, out_ready;
   logic [7:0]   in_index;
   logic         in_ready, out_valid, out_dup_err, out_range_err;
   logic [255:0] out_mask;
   logic [8:0]   out_count;

   logic         in10_valid, in10_last, out10_ready;
   logic [3:0]   in10_index;
   logic         in10_ready, out10_valid, out10_dup_err, out10_range_err;
   logic [9:0]   out10_mask;
   logic [3:0]   out10_count;

   int n_assert = 0;
   int n_fail   = 0;
   logic [255:0] exp_mask;
   int perm[256];

   always #5 clk = ~clk;

   index_to_mask #(.NUM_SPINS(256)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_index(in_index), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask), .out_count(out_count),
      .out_dup_err(out_dup_err), .out_range_err(out_range_err)
   );

   index_to_mask #(.NUM_SPINS(10)) dut10 (
      .clk(clk), .reset(reset),
      .in_valid(in10_valid), .in_ready(in10_ready), .in_index(in10_index), .in_last(in10_last),
      .out_valid(out10_valid), .out_ready(out10_ready), .out_mask(out10_mask), .out_count(out10_count),
      .out_dup_err(out10_dup_err), .out_range_err(out10_range_err)
   );

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_assert++;
      if (obs !== exp) begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] idx, input logic last);
      in_valid = 1'b1;
      in_index = idx;
      in_last  = last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send10(input logic [3:0] idx, input logic last);
      in10_valid = 1'b1;
      in10_index = idx;
      in10_last  = last;
      tick();
      in10_valid = 1'b0;
      in10_last  = 1'b0;
   endtask

   task automatic handoff();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      in_valid = 1'b0; in_last = 1'b0; in_index = '0; out_ready = 1'b0;
      in10_valid = 1'b0; in10_last = 1'b0; in10_index = '0; out10_ready = 1'b0;
      tick(); tick();
      reset = 1'b0;

      // reset values
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_mask", out_mask, 256'd0);
      chk("rst_count", out_count, 9'd0);
      chk("rst_dup", out_dup_err, 1'b0);
      chk("rst_range", out_range_err, 1'b0);

      // basic list 3, 0, 255(last)
      send(8'd3, 1'b0);
      send(8'd0, 1'b0);
      chk("basic_no_valid_yet", out_valid, 1'b0);
      send(8'd255, 1'b1);
      exp_mask = '0; exp_mask[0] = 1'b1; exp_mask[3] = 1'b1; exp_mask[255] = 1'b1;
      chk("basic_valid", out_valid, 1'b1);
      chk("basic_in_ready", in_ready, 1'b0);
      chk("basic_mask", out_mask, exp_mask);
      chk("basic_count", out_count, 9'd3);
      chk("basic_dup", out_dup_err, 1'b0);
      chk("basic_range", out_range_err, 1'b0);
      handoff();
      chk("basic_ho_ready", in_ready, 1'b1);
      chk("basic_ho_valid", out_valid, 1'b0);
      chk("basic_ho_mask", out_mask, 256'd0);
      chk("basic_ho_count", out_count, 9'd0);

      // duplicates 7, 7, 9(last)
      send(8'd7, 1'b0);
      send(8'd7, 1'b0);
      send(8'd9, 1'b1);
      exp_mask = '0; exp_mask[7] = 1'b1; exp_mask[9] = 1'b1;
      chk("dup_mask", out_mask, exp_mask);
      chk("dup_count", out_count, 9'd2);
      chk("dup_flag", out_dup_err, 1'b1);
      chk("dup_range", out_range_err, 1'b0);
      handoff();
      send(8'd1, 1'b1);
      exp_mask = '0; exp_mask[1] = 1'b1;
      chk("dup_next_mask", out_mask, exp_mask);
      chk("dup_next_count", out_count, 9'd1);
      chk("dup_next_flag", out_dup_err, 1'b0);
      handoff();

      // backpressure with a held beat
      send(8'd20, 1'b0);
      send(8'd21, 1'b1);
      in_valid = 1'b1; in_index = 8'd30; in_last = 1'b1;
      exp_mask = '0; exp_mask[20] = 1'b1; exp_mask[21] = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_in_ready", in_ready, 1'b0);
         chk("bp_valid", out_valid, 1'b1);
         chk("bp_mask", out_mask, exp_mask);
         chk("bp_count", out_count, 9'd2);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("bp_ho_ready", in_ready, 1'b1);
      chk("bp_ho_valid", out_valid, 1'b0);
      chk("bp_ho_count", out_count, 9'd0);
      tick();
      in_valid = 1'b0; in_last = 1'b0;
      exp_mask = '0; exp_mask[30] = 1'b1;
      chk("bp_held_valid", out_valid, 1'b1);
      chk("bp_held_mask", out_mask, exp_mask);
      chk("bp_held_count", out_count, 9'd1);
      handoff();

      // full mask, random order
      for (int i = 0; i < 256; i++) perm[i] = i;
      for (int i = 255; i > 0; i--) begin
         int j, t;
         j = int'($urandom_range(i, 0));
         t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      for (int i = 0; i < 256; i++) send(8'(perm[i]), i == 255);
      chk("full_valid", out_valid, 1'b1);
      chk("full_mask", out_mask, {256{1'b1}});
      chk("full_count", out_count, 9'd256);
      chk("full_dup", out_dup_err, 1'b0);
      handoff();

      // out-of-range index on a 10-spin instance
      send10(4'd4, 1'b0);
      send10(4'd12, 1'b1);
      chk("r10_valid", out10_valid, 1'b1);
      chk("r10_mask", out10_mask, 10'b00_0001_0000);
      chk("r10_count", out10_count, 4'd1);
      chk("r10_range", out10_range_err, 1'b1);
      chk("r10_dup", out10_dup_err, 1'b0);
      out10_ready = 1'b1;
      tick();
      out10_ready = 1'b0;
      chk("r10_ho_range", out10_range_err, 1'b0);
      send10(4'd9, 1'b1);
      chk("r10_top_mask", out10_mask, 10'b10_0000_0000);
      chk("r10_top_range", out10_range_err, 1'b0);
      out10_ready = 1'b1;
      tick();
      out10_ready = 1'b0;

      // reset mid-list, then in OUTPUT
      send(8'd40, 1'b0);
      send(8'd41, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rmid_mask", out_mask, 256'd0);
      chk("rmid_count", out_count, 9'd0);
      chk("rmid_ready", in_ready, 1'b1);
      chk("rmid_valid", out_valid, 1'b0);
      send(8'd5, 1'b1);
      exp_mask = '0; exp_mask[5] = 1'b1;
      chk("rmid_next_mask", out_mask, exp_mask);
      chk("rmid_next_count", out_count, 9'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rout_valid", out_valid, 1'b0);
      chk("rout_mask", out_mask, 256'd0);

      // streaming single-beat lists: one mask every two cycles
      in_valid = 1'b1; in_last = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         in_index = 8'(k * 37 + 2);
         tick();
         exp_mask = '0; exp_mask[k * 37 + 2] = 1'b1;
         chk("st_valid", out_valid, 1'b1);
         chk("st_mask", out_mask, exp_mask);
         chk("st_count", out_count, 9'd1);
         tick();
         chk("st_bubble_valid", out_valid, 1'b0);
         chk("st_bubble_ready", in_ready, 1'b1);
      end
      in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
